// File: rtl/sram_responder.sv
// Single-cycle SRAM responder: byte-lane writes, write-first read data.
// Define SRAM_RESPONDER_STATS_EN to build the rd/wr/err access counters.
module sram_responder #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic [31:0] err_cnt
);

  localparam int          WORDS = 1 << DEPTH_LOG2;
  // 33 bits so the byte-size limit cannot wrap for large depths
  localparam logic [32:0] LIMIT = 33'd4 << DEPTH_LOG2;

  logic [31:0]           mem [WORDS];
  logic [31:0]           offset;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  is_wr;
  logic                  do_wr;
  logic [31:0]           merged;

  always_comb begin
    offset   = sram_addr - BASE_ADDR;
    in_range = {1'b0, offset} < LIMIT;
    idx      = offset[DEPTH_LOG2+1:2];
    is_wr    = |sram_wen;
    do_wr    = !rst && sram_en && in_range && is_wr;
    merged   = mem[idx];
    for (int i = 0; i < 4; i++) begin
      if (sram_wen[i]) merged[8*i +: 8] = sram_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[idx] <= merged;
  end

  // Reads see merged == mem[idx] since no lane is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_rdata <= 32'h0;
    end else if (sram_en) begin
      if (in_range)    sram_rdata <= merged;
      else if (!is_wr) sram_rdata <= 32'h0;
    end
  end

`ifdef SRAM_RESPONDER_STATS_EN
  logic do_rd;
  logic do_err;

  always_comb begin
    do_rd  = !rst && sram_en && in_range && !is_wr;
    do_err = !rst && sram_en && !in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt  <= 32'h0;
      wr_cnt  <= 32'h0;
      err_cnt <= 32'h0;
    end else begin
      if (do_rd && rd_cnt != 32'hffffffff)
        rd_cnt <= rd_cnt + 32'd1;
      if (do_wr && wr_cnt != 32'hffffffff)
        wr_cnt <= wr_cnt + 32'd1;
      if (do_err && err_cnt != 32'hffffffff)
        err_cnt <= err_cnt + 32'd1;
    end
  end
`else
  assign rd_cnt  = 32'h0;
  assign wr_cnt  = 32'h0;
  assign err_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Randomized scoreboard bench for sram_responder.
// Counter expectations follow SRAM_RESPONDER_STATS_EN.
module tb_sram_responder;

  localparam int          DL2  = 12;
  localparam logic [31:0] BASE = 32'hbfc00000;
  localparam longint      SIZE = 4 * (longint'(1) << DL2);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_wen = 4'h0;
  logic [31:0] sram_addr = 32'h0;
  logic [31:0] sram_wdata = 32'h0;
  logic [31:0] sram_rdata, rd_cnt, wr_cnt, err_cnt;

  sram_responder #(.DEPTH_LOG2(DL2), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .sram_en(sram_en),
    .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] rc;
    logic [31:0] wc;
    logic [31:0] ec;
    bit          chk;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] mdl [longint];
  logic [31:0] m_rd = 32'h0;
  bit          m_known = 1'b1;
  longint      m_rc = 0, m_wc = 0, m_ec = 0;

  function automatic longint sat(longint c);
    return (c < 64'hffffffff) ? c + 1 : c;
  endfunction

  task automatic model(bit r, bit en, logic [3:0] wen,
                       logic [31:0] addr, logic [31:0] wd);
    longint off, idx;
    logic [31:0] w;
    if (r) begin
      m_rd = 0; m_known = 1; m_rc = 0; m_wc = 0; m_ec = 0;
      return;
    end
    if (!en) return;
    off = longint'(32'(addr - BASE));
    if (off < SIZE) begin
      idx = off / 4;
      if (wen == 4'h0) begin
        m_known = mdl.exists(idx);
        m_rd = m_known ? mdl[idx] : 32'h0;
        m_rc = sat(m_rc);
      end else begin
        m_known = mdl.exists(idx);
        w = m_known ? mdl[idx] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (wen[b]) w[8*b +: 8] = wd[8*b +: 8];
        if (wen == 4'hf) m_known = 1;
        mdl[idx] = w;
        m_rd = w;
        m_wc = sat(m_wc);
      end
    end else begin
      if (wen == 4'h0) begin
        m_rd = 0; m_known = 1;
      end
      m_ec = sat(m_ec);
    end
  endtask

  task automatic drive(bit r, bit en, logic [3:0] wen,
                       logic [31:0] addr, logic [31:0] wd,
                       string tag);
    exp_t e;
    @(negedge clk);
    rst = r; sram_en = en; sram_wen = wen;
    sram_addr = addr; sram_wdata = wd;
    model(r, en, wen, addr, wd);
    e.rd = m_rd; e.chk = m_known; e.tag = tag;
`ifdef SRAM_RESPONDER_STATS_EN
    e.rc = 32'(m_rc); e.wc = 32'(m_wc); e.ec = 32'(m_ec);
`else
    e.rc = 0; e.wc = 0; e.ec = 0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic cmp(string n, string tag,
                     logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h",
               tag, n, got, want);
    end
  endtask

  // monitor: one expected entry per driven cycle
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk) cmp("rdata", e.tag, sram_rdata, e.rd);
      cmp("rd_cnt", e.tag, rd_cnt, e.rc);
      cmp("wr_cnt", e.tag, wr_cnt, e.wc);
      cmp("err_cnt", e.tag, err_cnt, e.ec);
    end
  end

  function automatic logic [31:0] pick_addr();
    int k = $urandom_range(0, 9);
    logic [31:0] a;
    if (k < 7)
      a = BASE + 32'($urandom_range(0, 15) * 4);
    else if (k == 7)
      a = BASE + 32'(SIZE) - 32'($urandom_range(1, 8) * 4);
    else if (k == 8)
      a = (($urandom_range(0, 1) == 0) ?
           BASE + 32'(SIZE) : BASE - 32'd4);
    else
      a = $urandom;
    return a | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [3:0] w;
    int n;
    drive(1, 0, 4'h0, 32'h0, 32'h0, "reset");
    drive(1, 0, 4'h0, 32'h0, 32'h0, "reset");
    // first cycle out of reset: accepted write
    drive(0, 1, 4'hf, 32'hbfc00010, 32'h12345678, "wr10");
    drive(0, 1, 4'h0, 32'hbfc00010, 32'h0, "rd10");
    drive(0, 0, 4'hf, 32'hbfc00010, 32'hdeadbeef, "idle");
    drive(0, 1, 4'hf, 32'hbfc00020, 32'hffffffff, "fill20");
    drive(0, 1, 4'b0100, 32'hbfc00020, 32'h00aa0000, "part20");
    drive(0, 1, 4'h0, 32'hbfc00020, 32'h0, "rd20");
    drive(0, 1, 4'h0, 32'h00000000, 32'h0, "oor_rd");
    drive(0, 1, 4'hf, BASE + 32'(SIZE), 32'h55555555, "oor_wr");
    drive(0, 1, 4'hf, 32'hbfc00024, 32'hcafef00d, "wr24");
    drive(0, 1, 4'h0, 32'hbfc00027, 32'h0, "rd27");
    // fill the random window so every read is predictable
    for (int i = 0; i < 16; i++)
      drive(0, 1, 4'hf, BASE + 32'(i * 4), $urandom, "fill");
    for (int i = 1; i <= 8; i++)
      drive(0, 1, 4'hf, BASE + 32'(SIZE) - 32'(i * 4), $urandom, "fillhi");
    drive(0, 1, 4'h0, BASE + 32'(SIZE) - 32'd4, 32'h0, "rdtop");
    // reset mid-stream with a write pending
    drive(0, 1, 4'hf, 32'hbfc00010, 32'h0badc0de, "prerst");
    drive(1, 1, 4'hf, 32'hbfc00010, 32'h11111111, "rstwr");
    drive(0, 1, 4'h0, 32'hbfc00010, 32'h0, "postrst");
    n = 2000;
    for (int i = 0; i < n; i++) begin
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            w, pick_addr(), $urandom, "rand");
    end
    drive(0, 0, 4'h0, 32'h0, 32'h0, "drain");
    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
